// File: rtl/lab7_soc_switch_debounce.sv
// Switch conditioning ahead of the 20-bit PIO in_port.
// The raw levels pass through a 2-flop synchronizer, then each bit has its own stability filter.

module lab7_soc_switch_debounce_bit #(
  parameter int STABLE_CYCLES = 50000,
  parameter int CNT_W         = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sync_in,
  output logic clean,
  output logic changed,
  output logic flip
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  // Combinational flip request; the top ORs these so any_change lands in the same cycle.
  assign flip = (sync_in != clean) && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt     <= '0;
      clean   <= 1'b0;
      changed <= 1'b0;
    end else if (sync_in == clean) begin
      cnt     <= '0;
      changed <= 1'b0;
    end else if (flip) begin
      clean   <= sync_in;
      cnt     <= '0;
      changed <= 1'b1;
    end else begin
      cnt     <= cnt + 1'b1;
      changed <= 1'b0;
    end
  end
endmodule

module lab7_soc_switch_debounce #(
  parameter int WIDTH         = 20,
  parameter int STABLE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_clean,
  output logic [WIDTH-1:0] sw_changed,
  output logic             any_change
);
  localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;

  logic [WIDTH-1:0] sync1, sync2, flip;

  // The sync stages clear on reset so a held switch re-qualifies over the full latency.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1      <= '0;
      sync2      <= '0;
      any_change <= 1'b0;
    end else begin
      sync1      <= sw_raw;
      sync2      <= sync1;
      any_change <= |flip;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    lab7_soc_switch_debounce_bit #(
      .STABLE_CYCLES(STABLE_CYCLES),
      .CNT_W        (CNT_W)
    ) u_bit (
      .clk    (clk),
      .reset_n(reset_n),
      .sync_in(sync2[i]),
      .clean  (sw_clean[i]),
      .changed(sw_changed[i]),
      .flip   (flip[i])
    );
  end
endmodule

// File: tb/tb_lab7_soc_switch_debounce.sv
// Bench for the switch debouncer: vector table, corner-case sequences, and random traffic
// checked against a sliding-window model, on a STABLE_CYCLES=4 and a STABLE_CYCLES=1 build.

module tb_lab7_soc_switch_debounce;
  localparam int W = 20;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [W-1:0] raw4, raw1, clean4, chg4, clean1, chg1;
  logic         any4, any1;

  always #5 clk = ~clk;

  lab7_soc_switch_debounce #(.WIDTH(W), .STABLE_CYCLES(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .sw_raw(raw4),
    .sw_clean(clean4), .sw_changed(chg4), .any_change(any4));

  lab7_soc_switch_debounce #(.WIDTH(W), .STABLE_CYCLES(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .sw_raw(raw1),
    .sw_clean(clean1), .sw_changed(chg1), .any_change(any1));

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: the synchronizer is raw delayed two edges; a bit flips when the last S
  // synchronized samples since reset all disagree with its clean value.
  logic [W-1:0] m_s1[2], m_s2[2], m_clean[2], m_chg[2];
  logic [W-1:0] m_hist[2][4];
  int           m_n[2];

  task automatic model_edge(input int m, input int s, input logic [W-1:0] r);
    logic [W-1:0] nchg;
    logic         ok;
    if (!reset_n) begin
      m_s1[m] = '0; m_s2[m] = '0; m_clean[m] = '0; m_chg[m] = '0; m_n[m] = 0;
    end else begin
      for (int j = 3; j > 0; j--) m_hist[m][j] = m_hist[m][j-1];
      m_hist[m][0] = m_s2[m];
      if (m_n[m] < 4) m_n[m]++;
      nchg = '0;
      if (m_n[m] >= s)
        for (int b = 0; b < W; b++) begin
          ok = 1'b1;
          for (int j = 0; j < s; j++)
            if (m_hist[m][j][b] == m_clean[m][b]) ok = 1'b0;
          nchg[b] = ok;
        end
      m_clean[m] = m_clean[m] ^ nchg;
      m_chg[m]   = nchg;
      m_s2[m]    = m_s1[m];
      m_s1[m]    = r;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge(0, 4, raw4);
    model_edge(1, 1, raw1);
    #1;
  endtask

  task automatic rst2();
    reset_n = 1'b0; raw4 = '0; raw1 = '0;
    step(); step();
    reset_n = 1'b1;
  endtask

  typedef struct {
    logic         rst_n;
    logic [W-1:0] raw;
    logic [W-1:0] clean;
    logic [W-1:0] chg;
    logic         any;
  } vec_t;

  vec_t tbl[19];
  int   nt;

  task automatic add(input logic r, input logic [W-1:0] rw, input logic [W-1:0] c,
                     input logic [W-1:0] g, input logic a, input int rep);
    for (int i = 0; i < rep; i++) begin
      tbl[nt] = '{rst_n: r, raw: rw, clean: c, chg: g, any: a};
      nt++;
    end
  endtask

  initial begin
    int pulses;
    logic [W-1:0] e_clean, e_chg;

    reset_n = 1'b0; raw4 = '0; raw1 = '0;
    for (int m = 0; m < 2; m++) begin
      m_s1[m] = '0; m_s2[m] = '0; m_clean[m] = '0; m_chg[m] = '0; m_n[m] = 0;
      for (int j = 0; j < 4; j++) m_hist[m][j] = '0;
    end

    // Reset with all switches high, release, then a clean step on bit 0.
    nt = 0;
    add(1'b0, 20'hFFFFF, 20'h00000, 20'h00000, 1'b0, 3);
    add(1'b1, 20'hFFFFF, 20'h00000, 20'h00000, 1'b0, 5);
    add(1'b1, 20'hFFFFF, 20'hFFFFF, 20'hFFFFF, 1'b1, 1);
    add(1'b1, 20'hFFFFF, 20'hFFFFF, 20'h00000, 1'b0, 1);
    add(1'b0, 20'h00000, 20'h00000, 20'h00000, 1'b0, 2);
    add(1'b1, 20'h00001, 20'h00000, 20'h00000, 1'b0, 5);
    add(1'b1, 20'h00001, 20'h00001, 20'h00001, 1'b1, 1);
    add(1'b1, 20'h00001, 20'h00001, 20'h00000, 1'b0, 1);
    for (int i = 0; i < nt; i++) begin
      reset_n = tbl[i].rst_n;
      raw4    = tbl[i].raw;
      step();
      chk($sformatf("tbl%0d_clean", i), clean4, tbl[i].clean);
      chk($sformatf("tbl%0d_chg", i), chg4, tbl[i].chg);
      chk($sformatf("tbl%0d_any", i), W'(any4), W'(tbl[i].any));
    end

    // Bounce on bit 5: high 3, low 1, then steady high.
    rst2();
    pulses = 0;
    for (int k = 1; k <= 12; k++) begin
      raw4 = '0;
      raw4[5] = (k <= 3) || (k >= 5);
      step();
      e_clean = '0; e_clean[5] = (k >= 10);
      e_chg   = '0; e_chg[5]   = (k == 10);
      if (chg4[5]) pulses++;
      chk($sformatf("bounce_clean_e%0d", k), clean4, e_clean);
      chk($sformatf("bounce_chg_e%0d", k), chg4, e_chg);
    end
    chk("bounce_pulse_count", W'(pulses), W'(1));

    // Bits 3 and 19 rise together; bit 3 drops after two cycles.
    rst2();
    for (int k = 1; k <= 9; k++) begin
      raw4 = '0;
      raw4[19] = 1'b1;
      raw4[3]  = (k <= 2);
      step();
      chk($sformatf("simul_clean_e%0d", k), clean4, (k >= 6) ? 20'h80000 : 20'h00000);
      chk($sformatf("simul_chg_e%0d", k), chg4, (k == 6) ? 20'h80000 : 20'h00000);
      chk($sformatf("simul_any_e%0d", k), W'(any4), W'(k == 6));
    end

    // Reset for one edge in the middle of a count on bit 7.
    rst2();
    for (int k = 1; k <= 11; k++) begin
      raw4 = '0;
      raw4[7] = 1'b1;
      reset_n = (k != 4);
      step();
      e_clean = '0; e_clean[7] = (k >= 10);
      e_chg   = '0; e_chg[7]   = (k == 10);
      chk($sformatf("midrst_clean_e%0d", k), clean4, e_clean);
      chk($sformatf("midrst_chg_e%0d", k), chg4, e_chg);
    end
    reset_n = 1'b1;

    // STABLE_CYCLES=1: step on bit 2 flips after edge 3.
    rst2();
    for (int k = 1; k <= 4; k++) begin
      raw1 = 20'h00004;
      step();
      chk($sformatf("s1_step_clean_e%0d", k), clean1, (k >= 3) ? 20'h00004 : 20'h00000);
      chk($sformatf("s1_step_chg_e%0d", k), chg1, (k == 3) ? 20'h00004 : 20'h00000);
    end

    // Glitch that sits between two sampling edges never reaches the filter.
    rst2();
    for (int k = 1; k <= 5; k++) begin
      step();
      if (k == 1) begin
        raw1[0] = 1'b1;
        #3;
        raw1[0] = 1'b0;
      end
      chk($sformatf("s1_unsampled_clean_e%0d", k), clean1, 20'h00000);
      chk($sformatf("s1_unsampled_chg_e%0d", k), chg1, 20'h00000);
    end

    // Glitch held across exactly one edge passes through as a one-cycle clean pulse.
    rst2();
    for (int k = 1; k <= 6; k++) begin
      raw1 = (k == 1) ? 20'h00001 : 20'h00000;
      step();
      chk($sformatf("s1_sampled_clean_e%0d", k), clean1, (k == 3) ? 20'h00001 : 20'h00000);
      chk($sformatf("s1_sampled_chg_e%0d", k), chg1,
          (k == 3 || k == 4) ? 20'h00001 : 20'h00000);
      chk($sformatf("s1_sampled_any_e%0d", k), W'(any1), W'(k == 3 || k == 4));
    end

    // Random traffic against the model on both builds.
    rst2();
    for (int c = 0; c < 4000; c++) begin
      for (int b = 0; b < W; b++) begin
        if ($urandom_range(7) == 0) raw4[b] = ~raw4[b];
        if ($urandom_range(2) == 0) raw1[b] = ~raw1[b];
      end
      reset_n = ($urandom_range(299) != 0);
      step();
      chk("rnd_clean4", clean4, m_clean[0]);
      chk("rnd_chg4", chg4, m_chg[0]);
      chk("rnd_any4", W'(any4), W'(|m_chg[0]));
      chk("rnd_clean1", clean1, m_clean[1]);
      chk("rnd_chg1", chg1, m_chg[1]);
      chk("rnd_any1", W'(any1), W'(|m_chg[1]));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
